pi_request: RTL and testbench

PI_REQUEST -- requirements
Module: pi_request

---
 rtl/pi_request_pkg.sv | 16 +
 rtl/pi_request_sync2.sv | 31 +++
 rtl/pi_request.sv | 131 +++++++++++++
 tb/tb_pi_request.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pi_request_pkg.sv
// Shared definitions for the Pi request path: bus widths and the request FSM
// state encoding. Imported by pi_request and by any block that talks to the
// same bus (sync, bus model).
package pi_request_pkg;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_RELEASE = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

endpackage

// File: rtl/pi_request_sync2.sv
// sync2: generic two-flop synchronizer for slow level signals crossing into
// the clk domain. Synchronous active-high reset clears both stages.
// Ports:
//   clk    - destination clock
//   reset  - synchronous active-high reset
//   d      - asynchronous input
//   q      - synchronized output (two clk edges of latency)
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // the pre-edge value of the others; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pi_request.sv
// pi_request: turns one command from the Pi/SPI side into a single bus slot
// request, waits for the slot-completed flag (or a timeout), then reports a
// one-cycle response.
// Ports:
//   clk16, reset                 - 16 MHz clock, synchronous active-high reset
//   cmd_valid/cmd_ready          - command handshake (accept when both high)
//   cmd_rw, cmd_addr, cmd_data   - command: 1=read/0=write, address, write data
//   pending                      - request to the bus-slot arbiter
//   done                         - slot completed (asynchronous, synchronized here)
//   bus_addr, bus_rw, bus_wdata  - latched command driven to the bus
//   bus_rdata                    - read data from the bus, valid while done=1
//   rsp_valid, rsp_timeout       - completion pulse and its abort qualifier
//   rsp_data                     - last read result, held until overwritten
module pi_request
  import pi_request_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk16,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rw,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              pending,
  input  logic              done,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_rw,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_timeout
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  state_t           state_next;
  logic             done_s;
  logic [CNT_W-1:0] count;
  logic             timeout_flag;
  logic             accept;
  logic             expire;

  sync2 #(.WIDTH(1)) u_done_sync (
    .clk   (clk16),
    .reset (reset),
    .d     (done),
    .q     (done_s)
  );

  always_ff @(posedge clk16) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    pending     = 1'b0;
    rsp_valid   = 1'b0;
    rsp_timeout = 1'b0;
    accept      = 1'b0;
    expire      = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept     = 1'b1;
          state_next = S_PENDING;
        end
      end
      S_PENDING: begin
        pending = 1'b1;
        // A completion seen on the last allowed cycle still counts as done.
        if (done_s) begin
          state_next = S_RELEASE;
        end else if (count == CNT_LAST) begin
          expire     = 1'b1;
          state_next = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Hold off until sync drops done, so the next request cannot be
        // mistaken as already completed.
        if (!done_s) state_next = S_RESPOND;
      end
      S_RESPOND: begin
        rsp_valid   = 1'b1;
        rsp_timeout = timeout_flag;
        state_next  = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: all datapath registers are reset, including rsp_data and the bus
  // latches, so outputs are defined immediately after reset release.
  always_ff @(posedge clk16) begin
    if (reset) begin
      bus_addr     <= '0;
      bus_rw       <= 1'b0;
      bus_wdata    <= '0;
      rsp_data     <= '0;
      count        <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (accept) begin
        bus_addr     <= cmd_addr;
        bus_rw       <= cmd_rw;
        bus_wdata    <= cmd_data;
        count        <= '0;
        timeout_flag <= 1'b0;
      end
      if (state == S_PENDING) begin
        timeout_flag <= expire;
        if (done_s) begin
          if (bus_rw) rsp_data <= bus_rdata;
        end else if (count != CNT_LAST) begin
          count <= count + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pi_request.sv
// Self-checking bench for pi_request: reset state, a table of directed
// transactions (read, write, timeout, done/timeout boundary, long done hold),
// back-to-back with cmd_valid held, reset mid-transaction, then random
// transactions checked against a cycle-count model of the handshake.
module tb_pi_request;

  localparam int TO = 16;

  logic        clk16;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_rw;
  logic [16:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        pending;
  logic        done;
  logic [16:0] bus_addr;
  logic        bus_rw;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_timeout;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] model_rsp;

  pi_request #(.TIMEOUT_CYCLES(TO)) dut (
    .clk16       (clk16),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_rw      (cmd_rw),
    .cmd_addr    (cmd_addr),
    .cmd_data    (cmd_data),
    .pending     (pending),
    .done        (done),
    .bus_addr    (bus_addr),
    .bus_rw      (bus_rw),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout)
  );

  initial clk16 = 1'b0;
  always #5 clk16 = ~clk16;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rw;
    logic [16:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    int          d;      // pending-high sample on which the bus raises done; -1 = never
    int          h;      // extra samples done stays high after pending falls
    logic        exp_to;
    logic [7:0]  exp_rsp;
  } vec_t;

  task automatic step();
    @(posedge clk16);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One full transaction with a cooperating bus model. Timing expectations come
  // from the handshake rules: done reaches the FSM two edges after it is
  // raised, pending lasts min(d+2, TO) samples, and the response comes once
  // both pending has fallen and the synchronized done has cleared.
  task automatic txn(input logic rw, input logic [16:0] addr, input logic [7:0] wd,
                     input logic [7:0] rd, input int d, input int h,
                     input logic exp_to, input logic [7:0] exp_rsp,
                     input logic hold_valid, input logic nrw,
                     input logic [16:0] naddr, input logic [7:0] nd);
    int wait_n = 0;
    int idx = 1;
    int pend_cnt = 0;
    int low_idx = -1;
    int rsp_idx = -1;
    int rsp_cnt = 0;
    int exp_len, exp_low, exp_rsp_idx;
    bit done_up = 0;
    bit bus_bad = 0;
    bit ready_bad = 0;
    bit reassert = 0;

    while (cmd_ready !== 1'b1 && wait_n < 50) begin
      step();
      wait_n++;
    end
    check("ready_before_accept", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = addr;
    cmd_data  = wd;
    step();
    check("pending_after_accept", 32'(pending), 32'd1);
    if (hold_valid) begin
      cmd_rw   = nrw;
      cmd_addr = naddr;
      cmd_data = nd;
    end else begin
      cmd_valid = 1'b0;
    end

    while (idx < 200) begin
      if (rsp_idx >= 0 && idx == rsp_idx + 1) break;
      if (pending) begin
        if (low_idx >= 0) reassert = 1;
        pend_cnt++;
      end else if (low_idx < 0) begin
        low_idx = idx;
      end
      if (bus_addr !== addr || bus_rw !== rw || bus_wdata !== wd) bus_bad = 1;
      if (cmd_ready !== 1'b0) ready_bad = 1;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_idx < 0) begin
          rsp_idx = idx;
          check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
          check("rsp_data", 32'(rsp_data), 32'(exp_rsp));
        end
      end
      if (d >= 0 && !done_up && pending && pend_cnt == d) begin
        done      = 1'b1;
        bus_rdata = rd;
        done_up   = 1;
      end else if (done_up && done && low_idx >= 0 && idx >= low_idx + h) begin
        done      = 1'b0;
        bus_rdata = 8'($urandom);
      end
      step();
      idx++;
    end

    if (hold_valid) cmd_valid = 1'b1;
    exp_len = (d < 0 || d + 2 > TO) ? TO : d + 2;
    exp_low = exp_len + 1;
    if (d < 0) exp_rsp_idx = exp_low + 1;
    else       exp_rsp_idx = (exp_low + 1 > exp_low + h + 3) ? exp_low + 1 : exp_low + h + 3;

    check("pending_cycles", 32'(pend_cnt), 32'(exp_len));
    check("pending_reassert", 32'(reassert), 32'd0);
    check("bus_stable", 32'(bus_bad), 32'd0);
    check("busy_ready_low", 32'(ready_bad), 32'd0);
    check("rsp_pulses", 32'(rsp_cnt), 32'd1);
    check("rsp_latency", 32'(rsp_idx), 32'(exp_rsp_idx));
    check("rsp_one_cycle", 32'(rsp_valid), 32'd0);
    check("ready_after_rsp", 32'(cmd_ready), 32'd1);
  endtask

  vec_t vecs[7];

  initial begin
    int cnt;
    vecs[0] = '{1'b1, 17'h08000, 8'h00, 8'hA5, 1,  0,  1'b0, 8'hA5};
    vecs[1] = '{1'b0, 17'h1E800, 8'h3C, 8'h11, 2,  1,  1'b0, 8'hA5};
    vecs[2] = '{1'b1, 17'h00001, 8'h00, 8'h22, -1, 0,  1'b1, 8'hA5};
    vecs[3] = '{1'b1, 17'h1FFFF, 8'h00, 8'h5A, 14, 0,  1'b0, 8'h5A};
    vecs[4] = '{1'b1, 17'h12345, 8'h00, 8'h77, 15, 3,  1'b1, 8'h5A};
    vecs[5] = '{1'b0, 17'h00000, 8'hFF, 8'h33, -1, 0,  1'b1, 8'h5A};
    vecs[6] = '{1'b1, 17'h0ABCD, 8'h00, 8'hC3, 3,  10, 1'b0, 8'hC3};

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_rw    = 1'b0;
    cmd_addr  = '0;
    cmd_data  = '0;
    done      = 1'b0;
    bus_rdata = '0;
    repeat (3) step();
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("reset_rsp_data", 32'(rsp_data), 32'd0);
    check("reset_bus_addr", 32'(bus_addr), 32'd0);
    check("reset_bus_rw", 32'(bus_rw), 32'd0);
    check("reset_bus_wdata", 32'(bus_wdata), 32'd0);
    reset = 1'b0;
    step();
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 7; i++) begin
      txn(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].rdata, vecs[i].d, vecs[i].h,
          vecs[i].exp_to, vecs[i].exp_rsp, 1'b0, 1'b0, '0, '0);
    end

    // Back-to-back: second command held on cmd_valid while the first is busy
    // with a long done hold; it must be ignored until the cycle after rsp_valid.
    txn(1'b1, 17'h0C0DE, 8'h00, 8'h6E, 2, 10, 1'b0, 8'h6E, 1'b1, 1'b0, 17'h05555, 8'hE1);
    txn(1'b0, 17'h05555, 8'hE1, 8'h44, 1, 0, 1'b0, 8'h6E, 1'b0, 1'b0, '0, '0);

    // Reset while pending: request drops at the next edge, no response.
    cmd_valid = 1'b1;
    cmd_rw    = 1'b1;
    cmd_addr  = 17'h0F0F0;
    cmd_data  = 8'h00;
    step();
    cmd_valid = 1'b0;
    repeat (3) step();
    check("pending_before_reset", 32'(pending), 32'd1);
    reset = 1'b1;
    step();
    check("pending_dropped_by_reset", 32'(pending), 32'd0);
    check("rsp_valid_during_reset", 32'(rsp_valid), 32'd0);
    check("rsp_data_cleared", 32'(rsp_data), 32'd0);
    reset = 1'b0;
    cnt = 0;
    repeat (20) begin
      step();
      if (rsp_valid) cnt++;
    end
    check("no_rsp_after_reset", 32'(cnt), 32'd0);
    txn(1'b1, 17'h10001, 8'h00, 8'h99, 4, 2, 1'b0, 8'h99, 1'b0, 1'b0, '0, '0);
    model_rsp = 8'h99;

    for (int i = 0; i < 40; i++) begin
      logic        rw;
      logic [16:0] addr;
      logic [7:0]  wd, rd;
      int          r, d, h;
      logic        to;
      rw   = 1'($urandom);
      addr = 17'($urandom);
      wd   = 8'($urandom);
      rd   = 8'($urandom);
      r    = int'($urandom_range(0, 15));
      d    = (r == 0) ? -1 : r;
      h    = int'($urandom_range(0, 4));
      to   = (d < 0 || d + 2 > TO);
      if (!to && rw) model_rsp = rd;
      txn(rw, addr, wd, rd, d, h, to, model_rsp, 1'b0, 1'b0, '0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
